// File: rtl/nn_pkg.sv
// nn_pkg: shared opcodes, instruction field positions and FSM state encoding
// for the neural-net sequencer.
package nn_pkg;
   localparam logic [3:0] OP_DENSE = 4'h1;
   localparam logic [3:0] OP_ACT   = 4'h2;
   localparam logic [3:0] OP_COST  = 4'h3;
   localparam logic [3:0] OP_END   = 4'hF;
   localparam int OPC_MSB = 11;
   localparam int OPC_LSB = 8;
   localparam int OPD_MSB = 7;
   localparam int OPD_LSB = 0;
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_LOAD_I, S_LOAD_W,
      S_Z, S_COSTP, S_BWD, S_DONE, S_ERR
   } state_t;
endpackage

// File: rtl/nn_layer_table.sv
// nn_layer_table: per-layer record of instruction address and row count,
// one write port, one combinational read port, cleared on reset.
module nn_layer_table #(
   parameter int LAYER_W = 3,
   parameter int ADDR_W  = 5,
   parameter int ROW_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [LAYER_W-1:0] wr_idx,
   input  logic [ADDR_W-1:0]  wr_pc,
   input  logic [ROW_W-1:0]   wr_rows,
   input  logic [LAYER_W-1:0] rd_idx,
   output logic [ADDR_W-1:0]  rd_pc,
   output logic [ROW_W-1:0]   rd_rows
);
   logic [ADDR_W+ROW_W-1:0] mem [2**LAYER_W];
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int i = 0; i < 2**LAYER_W; i++) mem[i] <= '0;
      else if (we)
         mem[wr_idx] <= {wr_pc, wr_rows};
   assign {rd_pc, rd_rows} = mem[rd_idx];
endmodule

// File: rtl/nn_sequencer.sv
// nn_sequencer: fetches 12-bit instructions and sequences the forward pass,
// the cost pulse and the reverse-order weight-update pass of the data path.
module nn_sequencer
   import nn_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int LAYER_W = 3,
   parameter int ROW_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               start,
   input  logic               dp_busy,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [11:0]        rd_data,
   output logic               i_is_load,
   output logic               w_is_load,
   output logic [LAYER_W-1:0] w_layer_index,
   output logic [ROW_W-1:0]   w_row_index,
   output logic               use_z,
   output logic               backprop_cost,
   output logic               load_w,
   output logic               is_update,
   output logic [3:0]         act_type,
   output logic [7:0]         cost_type,
   output logic               done,
   output logic               error
);
   state_t             state;
   logic [LAYER_W:0]   layer_cnt;
   logic [ROW_W-1:0]   last_row;
   logic [3:0]         opcode;
   logic [7:0]         operand;
   logic               go, bad_rows, tbl_we;
   logic [LAYER_W-1:0] tbl_idx;
   logic [ADDR_W-1:0]  tbl_pc;
   logic [ROW_W-1:0]   tbl_rows;
   logic               unused_pc;

   assign opcode   = rd_data[OPC_MSB:OPC_LSB];
   assign operand  = rd_data[OPD_MSB:OPD_LSB];
   assign go       = enable && !dp_busy;
   assign bad_rows = ROW_W < 8 && (operand >> ROW_W) != '0;
   assign tbl_we   = enable && state == S_DECODE && opcode == OP_DENSE && !layer_cnt[LAYER_W] && !bad_rows;
   // In COSTP the next layer to update is the last one loaded; in BWD it is the one below the current
   assign tbl_idx   = (state == S_BWD) ? w_layer_index - 1'b1 : layer_cnt[LAYER_W-1:0] - 1'b1;
   assign unused_pc = ^tbl_pc;

   // Strobes are decoded from state so a stall or freeze drops them in the same cycle
   assign i_is_load     = state == S_LOAD_I && go;
   assign w_is_load     = state == S_LOAD_W && go;
   assign use_z         = state == S_Z && go;
   assign backprop_cost = state == S_COSTP && go;
   assign is_update     = state == S_BWD && go;
   assign load_w        = state == S_BWD && enable;
   assign done          = state == S_DONE && enable;

   nn_layer_table #(.LAYER_W(LAYER_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) u_tbl (
      .clk(clk), .reset(reset), .we(tbl_we), .wr_idx(layer_cnt[LAYER_W-1:0]),
      .wr_pc(rd_addr), .wr_rows(operand[ROW_W-1:0]), .rd_idx(tbl_idx),
      .rd_pc(tbl_pc), .rd_rows(tbl_rows)
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state         <= S_IDLE;
         rd_addr       <= '0;
         layer_cnt     <= '0;
         last_row      <= '0;
         w_layer_index <= '0;
         w_row_index   <= '0;
         act_type      <= '0;
         cost_type     <= '0;
         error         <= 1'b0;
      end else if (enable) begin
         case (state)
            S_IDLE, S_ERR:
               if (start) begin
                  state     <= S_FETCH;
                  rd_addr   <= '0;
                  layer_cnt <= '0;
                  error     <= 1'b0;
               end
            S_FETCH: state <= S_WAIT;
            S_WAIT:  state <= S_DECODE;
            S_DECODE:
               if (tbl_we) begin
                  last_row      <= operand[ROW_W-1:0];
                  w_layer_index <= layer_cnt[LAYER_W-1:0];
                  w_row_index   <= '0;
                  state         <= S_LOAD_I;
               end else if (opcode == OP_ACT && !(&rd_addr)) begin
                  act_type <= operand[3:0];
                  rd_addr  <= rd_addr + 1'b1;
                  state    <= S_FETCH;
               end else if (opcode == OP_COST && layer_cnt != '0) begin
                  cost_type <= operand;
                  state     <= S_COSTP;
               end else if (opcode == OP_END) begin
                  state <= S_DONE;
               end else begin
                  state <= S_ERR;
                  error <= 1'b1;
               end
            S_LOAD_I: if (!dp_busy) state <= S_LOAD_W;
            S_LOAD_W:
               if (!dp_busy) begin
                  if (w_row_index == last_row) state <= S_Z;
                  else w_row_index <= w_row_index + 1'b1;
               end
            S_Z:
               if (!dp_busy) begin
                  layer_cnt <= layer_cnt + 1'b1;
                  if (&rd_addr) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                     state   <= S_FETCH;
                  end
               end
            S_COSTP:
               if (!dp_busy) begin
                  w_layer_index <= tbl_idx;
                  w_row_index   <= tbl_rows;
                  state         <= S_BWD;
               end
            S_BWD:
               if (!dp_busy) begin
                  if (w_row_index != '0) w_row_index <= w_row_index - 1'b1;
                  else if (w_layer_index != '0) begin
                     w_layer_index <= tbl_idx;
                     w_row_index   <= tbl_rows;
                  end else state <= S_DONE;
               end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_nn_sequencer.sv
// tb_nn_sequencer: runs directed and random programs and compares the observed
// strobe stream against an event list derived from the instruction semantics.
module tb_nn_sequencer;
   logic        clk = 1'b0;
   logic        reset, enable, start, dp_busy;
   logic [4:0]  rd_addr;
   logic [11:0] rd_data;
   logic        i_is_load, w_is_load, use_z, backprop_cost, load_w, is_update, done, error;
   logic [2:0]  w_layer_index;
   logic [7:0]  w_row_index;
   logic [3:0]  act_type;
   logic [7:0]  cost_type;
   logic [11:0] mem [32];
   int          checks = 0, errors = 0, cyc = 0;
   int          exp_q[$], got_q[$];
   logic [3:0]  exp_act = '0;
   logic [7:0]  exp_cost = '0;

   nn_sequencer dut (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .dp_busy(dp_busy),
      .rd_addr(rd_addr), .rd_data(rd_data), .i_is_load(i_is_load), .w_is_load(w_is_load),
      .w_layer_index(w_layer_index), .w_row_index(w_row_index), .use_z(use_z),
      .backprop_cost(backprop_cost), .load_w(load_w), .is_update(is_update),
      .act_type(act_type), .cost_type(cost_type), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      rd_data <= mem[rd_addr];
      cyc     <= cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ev(input int k, input int l, input int r);
      return (k << 16) | (l << 8) | r;
   endfunction

   function automatic logic [63:0] all_outs();
      return {28'd0, rd_addr, i_is_load, w_is_load, w_layer_index, w_row_index, use_z,
              backprop_cost, load_w, is_update, act_type, cost_type, done, error};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = 12'h000;
   endtask

   // Event kinds: 1 input load, 2 weight load, 3 use_z, 4 cost, 5 update, 6 done, 7 error
   task automatic build_exp();
      int pc = 0, nl = 0;
      int rows[8];
      bit fin = 0;
      logic [3:0] op;
      logic [7:0] opd;
      exp_q = {};
      while (!fin) begin
         op  = mem[pc][11:8];
         opd = mem[pc][7:0];
         if (op == 4'h1 && nl < 8) begin
            rows[nl] = int'(opd) + 1;
            exp_q.push_back(ev(1, nl, 0));
            for (int r = 0; r < rows[nl]; r++) exp_q.push_back(ev(2, nl, r));
            exp_q.push_back(ev(3, nl, 0));
            nl++;
            if (pc == 31) begin exp_q.push_back(ev(7, 0, 0)); fin = 1; end
            else pc++;
         end else if (op == 4'h2 && pc < 31) begin
            exp_act = opd[3:0];
            pc++;
         end else if (op == 4'h3 && nl > 0) begin
            exp_cost = opd;
            exp_q.push_back(ev(4, 0, 0));
            for (int l = nl - 1; l >= 0; l--)
               for (int r = rows[l] - 1; r >= 0; r--) exp_q.push_back(ev(5, l, r));
            exp_q.push_back(ev(6, 0, 0));
            fin = 1;
         end else if (op == 4'hF) begin
            exp_q.push_back(ev(6, 0, 0));
            fin = 1;
         end else begin
            exp_q.push_back(ev(7, 0, 0));
            fin = 1;
         end
      end
   endtask

   // mode 0: random busy/enable, 1: clean, 2: busy burst after 2nd weight load, 3: freeze mid-backward
   task automatic run(input int mode);
      int   tail = -1, first_i = -1, start_cyc, n_w = 0, n_u = 0, busy_left = 0, en_left = 0, n;
      logic err_prev;
      build_exp();
      got_q = {};
      @(posedge clk);
      #1 start = 1'b1; enable = 1'b1; dp_busy = 1'b0;
      start_cyc = cyc;
      err_prev = error;
      for (int i = 0; i < 3000 && tail != 0; i++) begin
         @(negedge clk);
         if (cyc == start_cyc + 1) begin
            check("err_clr", error, 0);
            check("addr0", rd_addr, 0);
         end
         n = $countones({i_is_load, w_is_load, use_z, backprop_cost, is_update});
         if (n > 0) check("one_strobe", n, 1);
         if (is_update) check("load_w_hi", load_w, 1);
         if (i_is_load && first_i < 0) first_i = cyc;
         if (mode == 2 && dp_busy) begin
            check("stall_strobe", w_is_load, 0);
            check("stall_row", w_row_index, 2);
            busy_left--;
         end
         if (mode == 3 && !enable) begin
            check("frz_load_w", load_w, 0);
            check("frz_update", is_update, 0);
            check("frz_row", w_row_index, 2);
            en_left--;
         end
         if (i_is_load) got_q.push_back(ev(1, int'(w_layer_index), 0));
         if (w_is_load) got_q.push_back(ev(2, int'(w_layer_index), int'(w_row_index)));
         if (use_z) got_q.push_back(ev(3, int'(w_layer_index), 0));
         if (backprop_cost) got_q.push_back(ev(4, 0, 0));
         if (is_update) got_q.push_back(ev(5, int'(w_layer_index), int'(w_row_index)));
         if (done) got_q.push_back(ev(6, 0, 0));
         if (error && !err_prev) got_q.push_back(ev(7, 0, 0));
         if (mode == 2 && w_is_load && ++n_w == 2) busy_left = 5;
         if (mode == 3 && is_update && ++n_u == 2) en_left = 3;
         if (tail > 0) tail--;
         if (tail < 0 && (done || (error && !err_prev))) tail = 3;
         err_prev = error;
         @(posedge clk);
         #1 start = 1'b0;
         if (mode == 0) begin
            dp_busy = $urandom_range(3) == 0;
            enable  = $urandom_range(7) != 0;
         end
         if (mode == 2) dp_busy = busy_left > 0;
         if (mode == 3) enable = en_left == 0;
      end
      enable = 1'b1;
      dp_busy = 1'b0;
      check("finished", tail == 0, 1);
      if (mode == 1) check("latency", first_i - start_cyc, 4);
      if (exp_q[exp_q.size()-1] == ev(7, 0, 0)) check("err_sticky", error, 1);
      check("len", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("ev%0d", i), got_q[i], exp_q[i]);
      check("act", act_type, exp_act);
      check("cost", cost_type, exp_cost);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; start = 1'b0; dp_busy = 1'b0;
      clear_mem();
      repeat (2) @(posedge clk);
      #1 check("rst_outs", all_outs(), 0);
      @(negedge clk) reset = 1'b0;
      @(negedge clk) check("idle_outs", all_outs(), 0);

      clear_mem();
      mem[0] = 12'h102; mem[1] = 12'h201; mem[2] = 12'h305; mem[3] = 12'hF00;
      run(1);
      clear_mem();
      mem[0] = 12'h101; mem[1] = 12'h103; mem[2] = 12'h322; mem[3] = 12'hF00;
      run(1);
      clear_mem();
      mem[0] = 12'h104; mem[1] = 12'hF00;
      run(2);
      clear_mem();
      mem[0] = 12'h104; mem[1] = 12'h307; mem[2] = 12'hF00;
      run(3);
      clear_mem();
      mem[0] = 12'h100; mem[1] = 12'h7AA; mem[2] = 12'hF00;
      run(0);
      clear_mem();
      for (int i = 0; i < 9; i++) mem[i] = 12'h100;
      mem[9] = 12'h301;
      run(0);
      clear_mem();
      mem[0] = 12'h102; mem[1] = 12'h201; mem[2] = 12'h305; mem[3] = 12'hF00;
      run(1);
      for (int i = 0; i < 32; i++) mem[i] = 12'h203;
      run(0);
      clear_mem();
      mem[0] = 12'h344;
      run(0);

      clear_mem();
      mem[0] = 12'h105; mem[1] = 12'h301; mem[2] = 12'hF00;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 50 && !w_is_load; i++) @(negedge clk);
      check("rst_reach", w_is_load, 1);
      reset = 1'b1;
      #1 check("rst_async", all_outs(), 0);
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_idle", all_outs(), 0);
      exp_act = '0;
      exp_cost = '0;
      run(1);

      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 32; i++) begin
            int k;
            k = $urandom_range(99);
            mem[i] = k < 40 ? {4'h1, 8'($urandom_range(6))} :
                     k < 70 ? {4'h2, 8'($urandom)} :
                     k < 82 ? {4'h3, 8'($urandom)} :
                     k < 92 ? 12'hF00 : {4'($urandom_range(14, 4)), 8'h00};
         end
         run(0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
